// File: rtl/switch_port_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_port_cfg
//  Purpose  : Configuration register bank for the switch output ports.
//             Terminates the memory-config bus (mem_en / mem_rd_wr /
//             mem_addr / mem_data) and holds one DW-bit destination address
//             per output port. The same table also answers registered DA
//             lookups from the packet router with a one-hot or multi-hot
//             output-port match.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in     1          single clock, all state on posedge
//    reset_n        in     1          asynchronous active-low reset
//    mem_en         in     1          config access strobe
//    mem_rd_wr      in     1          1 = write, 0 = read (qualified by mem_en)
//    mem_addr       in     AW         register index
//    mem_data       inout  DW         write data in / read data out, else 'z
//    lk_valid       in     1          router lookup request
//    lk_da          in     DW         destination address to match
//    lk_rsp_valid   out    1          lookup result valid, 1 cycle later
//    lk_port        out    NUM_PORTS  matching output ports (multi-hot)
//    lk_hit         out    1          OR of lk_port
//    cfg_all_valid  out    1          every register written since reset
// ============================================================================

module switch_port_cfg #(
  parameter int NUM_PORTS = 4,   // must equal 2**AW
  parameter int AW        = 2,
  parameter int DW        = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  // memory-config bus
  input  logic                 mem_en,
  input  logic                 mem_rd_wr,
  input  logic [AW-1:0]        mem_addr,
  inout  wire  [DW-1:0]        mem_data,
  // router lookup
  input  logic                 lk_valid,
  input  logic [DW-1:0]        lk_da,
  output logic                 lk_rsp_valid,
  output logic [NUM_PORTS-1:0] lk_port,
  output logic                 lk_hit,
  // status
  output logic                 cfg_all_valid
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DW-1:0]        addr_q [NUM_PORTS];
  logic [DW-1:0]        addr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid_q;
  logic [NUM_PORTS-1:0] valid_d;

  // Read-drive pipeline: data captured at the sampling edge and held on the
  // bus until the next edge.
  logic                 rd_drive_q;
  logic                 rd_drive_d;
  logic [DW-1:0]        rd_data_q;
  logic [DW-1:0]        rd_data_d;

  logic                 lk_rsp_valid_q;
  logic                 lk_rsp_valid_d;
  logic [NUM_PORTS-1:0] lk_port_q;
  logic [NUM_PORTS-1:0] lk_port_d;
  logic                 lk_hit_q;
  logic                 lk_hit_d;
  logic                 cfg_all_valid_q;
  logic                 cfg_all_valid_d;

  logic                 wr_en;
  logic                 rd_en;
  logic [NUM_PORTS-1:0] match;

  assign wr_en = mem_en &  mem_rd_wr;
  assign rd_en = mem_en & ~mem_rd_wr;

  // --------------------------------------------------------------------------
  // Per-entry comparators. They look at the registered table, so a write and
  // a lookup on the same edge see the pre-write value and valid bit.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_match
      assign match[i] = valid_q[i] & (addr_q[i] == lk_da);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_d[i] = addr_q[i];
    end
    valid_d = valid_q;

    if (wr_en) begin
      addr_d[mem_addr]  = mem_data;
      valid_d[mem_addr] = 1'b1;
    end
  end

  always_comb begin
    rd_drive_d = rd_en;
    // Clearing the capture register when idle keeps X on an undriven bus or
    // stale table contents out of the holding register.
    rd_data_d  = rd_en ? addr_q[mem_addr] : '0;
  end

  always_comb begin
    // With lk_valid low the outputs are forced to zero regardless of lk_da,
    // so an unknown DA between requests cannot reach the router.
    lk_rsp_valid_d = lk_valid;
    lk_port_d      = lk_valid ? match : '0;
    lk_hit_d       = |lk_port_d;
  end

  // Computed from the next-state valid vector so the flag rises on the very
  // edge that writes the last outstanding entry.
  assign cfg_all_valid_d = &valid_d;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_q[i] <= '0;
      end
      valid_q         <= '0;
      rd_drive_q      <= 1'b0;
      rd_data_q       <= '0;
      lk_rsp_valid_q  <= 1'b0;
      lk_port_q       <= '0;
      lk_hit_q        <= 1'b0;
      cfg_all_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_q[i] <= addr_d[i];
      end
      valid_q         <= valid_d;
      rd_drive_q      <= rd_drive_d;
      rd_data_q       <= rd_data_d;
      lk_rsp_valid_q  <= lk_rsp_valid_d;
      lk_port_q       <= lk_port_d;
      lk_hit_q        <= lk_hit_d;
      cfg_all_valid_q <= cfg_all_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The drive enable is a flop under async reset, so asserting reset_n
  // releases the bus immediately rather than at the next edge.
  assign mem_data      = rd_drive_q ? rd_data_q : {DW{1'bz}};

  assign lk_rsp_valid  = lk_rsp_valid_q;
  assign lk_port       = lk_port_q;
  assign lk_hit        = lk_hit_q;
  assign cfg_all_valid = cfg_all_valid_q;

endmodule

`default_nettype wire
